mem_region_switch: RTL and testbench

N-way address-region switch between an LSU block's memory port and NUM_REGIONS downstream memory ports (e.g. local memory, dcache, I/O window). It generalises the two-way local/global split: lanes of one request may target different regions, so the request is split into one sub-request per region over successive cycles. Per-region outstanding counters bound in-flight traffic and drive an `idle` flag for fences. Responses merge back through a round-robin arbiter.

---
 rtl/mem_region_switch.sv | 205 ++++++++++++++++++++
 tb/tb_mem_region_switch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_switch.sv
// N-way address-region switch: splits each LSU request into one sub-request per
// target region, tracks in-flight traffic per region and merges responses round-robin.
module mem_region_switch #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 16,
  parameter int FLAGS_WIDTH = 3,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter int MAX_PENDING = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_req_valid,
  output logic in_req_ready,
  input  logic [NUM_LANES-1:0] in_req_mask,
  input  logic in_req_rw,
  input  logic [NUM_LANES-1:0][DATA_SIZE-1:0] in_req_byteen,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_LANES-1:0][FLAGS_WIDTH-1:0] in_req_flags,
  input  logic [NUM_LANES-1:0][DATA_SIZE*8-1:0] in_req_data,
  input  logic [TAG_WIDTH-1:0] in_req_tag,
  output logic [NUM_REGIONS-1:0] out_req_valid,
  input  logic [NUM_REGIONS-1:0] out_req_ready,
  output logic [NUM_REGIONS-1:0][NUM_LANES-1:0] out_req_mask,
  output logic [NUM_REGIONS-1:0] out_req_rw,
  output logic [NUM_REGIONS-1:0][NUM_LANES-1:0][DATA_SIZE-1:0] out_req_byteen,
  output logic [NUM_REGIONS-1:0][NUM_LANES-1:0][ADDR_WIDTH-1:0] out_req_addr,
  output logic [NUM_REGIONS-1:0][NUM_LANES-1:0][FLAGS_WIDTH-1:0] out_req_flags,
  output logic [NUM_REGIONS-1:0][NUM_LANES-1:0][DATA_SIZE*8-1:0] out_req_data,
  output logic [NUM_REGIONS-1:0][TAG_WIDTH-1:0] out_req_tag,
  input  logic [NUM_REGIONS-1:0] out_rsp_valid,
  output logic [NUM_REGIONS-1:0] out_rsp_ready,
  input  logic [NUM_REGIONS-1:0][NUM_LANES-1:0] out_rsp_mask,
  input  logic [NUM_REGIONS-1:0][NUM_LANES-1:0][DATA_SIZE*8-1:0] out_rsp_data,
  input  logic [NUM_REGIONS-1:0][TAG_WIDTH-1:0] out_rsp_tag,
  output logic in_rsp_valid,
  input  logic in_rsp_ready,
  output logic [NUM_LANES-1:0] in_rsp_mask,
  output logic [NUM_LANES-1:0][DATA_SIZE*8-1:0] in_rsp_data,
  output logic [TAG_WIDTH-1:0] in_rsp_tag,
  output logic idle
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int CW = $clog2(MAX_PENDING) + 1;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e state_q, state_d;
  logic rw_q;
  logic [NUM_LANES-1:0][DATA_SIZE-1:0] byteen_q;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [NUM_LANES-1:0][FLAGS_WIDTH-1:0] flags_q;
  logic [NUM_LANES-1:0][DATA_SIZE*8-1:0] data_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [NUM_LANES-1:0] pendingMask_q, pendingMask_d;
  logic [NUM_LANES-1:0][RW-1:0] laneRegion_q, laneRegionIn;
  logic [NUM_REGIONS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rrPtr_q, rrPtr_d;

  logic [RW-1:0] curRegion;
  logic [NUM_LANES-1:0] curMask;
  logic curFound, subValid, subFire, lastFire, inFire, inLoad;
  logic [RW-1:0] rspGrant, rspCand;
  logic rspAny;
  int rspIdx;

  // Lowest matching region wins, so scan from the top down and let lower indices overwrite.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      laneRegionIn[l] = RW'(NUM_REGIONS - 1);
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        if ((in_req_addr[l] & REGION_MASK[r]) == REGION_BASE[r]) laneRegionIn[l] = RW'(r);
      end
    end
  end

  always_comb begin
    curRegion = '0;
    curFound  = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pendingMask_q[l] && !curFound) begin
        curRegion = laneRegion_q[l];
        curFound  = 1'b1;
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      curMask[l] = pendingMask_q[l] && (laneRegion_q[l] == curRegion);
    end
  end

  assign subValid = (state_q == HOLD) && (cnt_q[curRegion] != CW'(MAX_PENDING));
  assign subFire  = subValid && out_req_ready[curRegion];
  assign lastFire = subFire && ((pendingMask_q & ~curMask) == '0);
  assign inFire   = in_req_valid && in_req_ready;
  assign inLoad   = inFire && (in_req_mask != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (inLoad) state_d = HOLD;
      HOLD:    if (lastFire && !inLoad) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_req_ready   = (state_q == EMPTY) || lastFire;
    idle           = (state_q == EMPTY) && (cnt_q == '0);
    out_req_valid  = '0;
    out_req_mask   = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      out_req_rw[r]     = rw_q;
      out_req_byteen[r] = byteen_q;
      out_req_addr[r]   = addr_q;
      out_req_flags[r]  = flags_q;
      out_req_data[r]   = data_q;
      out_req_tag[r]    = tag_q;
    end
    if (subValid) begin
      out_req_valid[curRegion] = 1'b1;
      out_req_mask[curRegion]  = curMask;
    end
  end

  // A new request overrides the clear of the final sub-request fired in the same cycle.
  always_comb begin
    pendingMask_d = pendingMask_q;
    if (subFire) pendingMask_d = pendingMask_q & ~curMask;
    if (inFire)  pendingMask_d = in_req_mask;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGIONS; r++) begin
      cnt_d[r] = cnt_q[r];
      if ((out_req_valid[r] && out_req_ready[r]) && !(out_rsp_valid[r] && out_rsp_ready[r]))
        cnt_d[r] = cnt_q[r] + CW'(1);
      else if (!(out_req_valid[r] && out_req_ready[r]) && (out_rsp_valid[r] && out_rsp_ready[r]))
        cnt_d[r] = cnt_q[r] - CW'(1);
    end
  end

  // Round-robin search starts at the pointer and wraps past the last port.
  always_comb begin
    rspGrant = '0;
    rspCand  = '0;
    rspAny   = 1'b0;
    rspIdx   = 0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      rspIdx = int'(rrPtr_q) + i;
      if (rspIdx >= NUM_REGIONS) rspIdx = rspIdx - NUM_REGIONS;
      rspCand = RW'(rspIdx);
      if (!rspAny && out_rsp_valid[rspCand]) begin
        rspAny   = 1'b1;
        rspGrant = rspCand;
      end
    end
    in_rsp_valid  = rspAny;
    in_rsp_mask   = out_rsp_mask[rspGrant];
    in_rsp_data   = out_rsp_data[rspGrant];
    in_rsp_tag    = out_rsp_tag[rspGrant];
    out_rsp_ready = '0;
    if (rspAny) out_rsp_ready[rspGrant] = in_rsp_ready;
    rrPtr_d = rrPtr_q;
    if (rspAny && in_rsp_ready)
      rrPtr_d = (rspGrant == RW'(NUM_REGIONS - 1)) ? '0 : rspGrant + RW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pendingMask_q <= '0;
      laneRegion_q  <= '0;
      cnt_q         <= '0;
      rrPtr_q       <= '0;
      rw_q          <= 1'b0;
      byteen_q      <= '0;
      addr_q        <= '0;
      flags_q       <= '0;
      data_q        <= '0;
      tag_q         <= '0;
    end else begin
      pendingMask_q <= pendingMask_d;
      cnt_q         <= cnt_d;
      rrPtr_q       <= rrPtr_d;
      if (inFire) begin
        laneRegion_q <= laneRegionIn;
        rw_q         <= in_req_rw;
        byteen_q     <= in_req_byteen;
        addr_q       <= in_req_addr;
        flags_q      <= in_req_flags;
        data_q       <= in_req_data;
        tag_q        <= in_req_tag;
      end
    end
  end

endmodule

// File: tb/tb_mem_region_switch.sv
// Self-checking bench for mem_region_switch: directed scenarios plus random traffic,
// checked each cycle against a queue-based model of sub-requests, counters and arbitration.
module tb_mem_region_switch;

  localparam int NL = 4;
  localparam int NR = 3;
  localparam int AW = 30;
  localparam int DS = 4;
  localparam int TW = 16;
  localparam int FW = 3;
  localparam int MAXP = 2;
  localparam logic [NR-1:0][AW-1:0] TB_BASE = {30'h0, 30'h2000, 30'h1000};
  localparam logic [NR-1:0][AW-1:0] TB_MASK = {30'h0, 30'h3FFF_F000, 30'h3FFF_F000};

  logic clk, reset_n;
  logic in_req_valid, in_req_ready, in_req_rw;
  logic [NL-1:0] in_req_mask;
  logic [NL-1:0][DS-1:0] in_req_byteen;
  logic [NL-1:0][AW-1:0] in_req_addr;
  logic [NL-1:0][FW-1:0] in_req_flags;
  logic [NL-1:0][DS*8-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic [NR-1:0] out_req_valid, out_req_ready, out_req_rw;
  logic [NR-1:0][NL-1:0] out_req_mask;
  logic [NR-1:0][NL-1:0][DS-1:0] out_req_byteen;
  logic [NR-1:0][NL-1:0][AW-1:0] out_req_addr;
  logic [NR-1:0][NL-1:0][FW-1:0] out_req_flags;
  logic [NR-1:0][NL-1:0][DS*8-1:0] out_req_data;
  logic [NR-1:0][TW-1:0] out_req_tag;
  logic [NR-1:0] out_rsp_valid, out_rsp_ready;
  logic [NR-1:0][NL-1:0] out_rsp_mask;
  logic [NR-1:0][NL-1:0][DS*8-1:0] out_rsp_data;
  logic [NR-1:0][TW-1:0] out_rsp_tag;
  logic in_rsp_valid, in_rsp_ready;
  logic [NL-1:0] in_rsp_mask;
  logic [NL-1:0][DS*8-1:0] in_rsp_data;
  logic [TW-1:0] in_rsp_tag;
  logic idle;

  mem_region_switch #(
    .NUM_LANES(NL), .NUM_REGIONS(NR), .ADDR_WIDTH(AW), .DATA_SIZE(DS),
    .TAG_WIDTH(TW), .FLAGS_WIDTH(FW), .REGION_BASE(TB_BASE),
    .REGION_MASK(TB_MASK), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_mask(in_req_mask), .in_req_rw(in_req_rw),
    .in_req_byteen(in_req_byteen), .in_req_addr(in_req_addr),
    .in_req_flags(in_req_flags), .in_req_data(in_req_data),
    .in_req_tag(in_req_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_mask(out_req_mask), .out_req_rw(out_req_rw),
    .out_req_byteen(out_req_byteen), .out_req_addr(out_req_addr),
    .out_req_flags(out_req_flags), .out_req_data(out_req_data),
    .out_req_tag(out_req_tag),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready),
    .out_rsp_mask(out_rsp_mask), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .in_rsp_mask(in_rsp_mask), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {int r; logic [NL-1:0] m;} sub_t;
  sub_t subQ[$];
  int cnt[NR];
  int rrPtr;
  logic hRw;
  logic [NL-1:0][DS-1:0] hByteen;
  logic [NL-1:0][AW-1:0] hAddr;
  logic [NL-1:0][FW-1:0] hFlags;
  logic [NL-1:0][DS*8-1:0] hData;
  logic [TW-1:0] hTag;
  int errors, checks;
  int rspPct;
  bit rspFreeze;
  int dutFires1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int regionOf(input logic [AW-1:0] a);
    if (a >= 30'h1000 && a <= 30'h1FFF) return 0;
    if (a >= 30'h2000 && a <= 30'h2FFF) return 1;
    return 2;
  endfunction

  function automatic logic [AW-1:0] addrIn(input int r);
    logic [AW-1:0] a;
    if (r == 0) return 30'h1000 + AW'($urandom_range(0, 32'hFFF));
    if (r == 1) return 30'h2000 + AW'($urandom_range(0, 32'hFFF));
    a = AW'($urandom);
    if (a >= 30'h1000 && a <= 30'h2FFF) a = a | 30'h0010_0000;
    return a;
  endfunction

  // regSel holds a 2-bit target region per lane; any value of 2 or more means the fallback region.
  task automatic applyStimulus(input bit valid, input logic [NL-1:0] mask, input logic [7:0] regSel);
    int rs;
    in_req_valid = valid;
    in_req_mask  = mask;
    in_req_rw    = 1'($urandom);
    in_req_tag   = TW'($urandom);
    for (int l = 0; l < NL; l++) begin
      rs = int'(regSel[2*l +: 2]);
      in_req_addr[l]   = addrIn(rs > 2 ? 2 : rs);
      in_req_byteen[l] = DS'($urandom);
      in_req_flags[l]  = FW'($urandom);
      in_req_data[l]   = $urandom;
    end
  endtask

  task automatic loadModel();
    logic [NL-1:0] pend, m;
    int lo, r;
    hRw = in_req_rw; hByteen = in_req_byteen; hAddr = in_req_addr;
    hFlags = in_req_flags; hData = in_req_data; hTag = in_req_tag;
    pend = in_req_mask;
    while (pend != '0) begin
      lo = 0;
      for (int l = NL - 1; l >= 0; l--) if (pend[l]) lo = l;
      r = regionOf(in_req_addr[lo]);
      m = '0;
      for (int l = 0; l < NL; l++) if (pend[l] && regionOf(in_req_addr[l]) == r) m[l] = 1'b1;
      subQ.push_back('{r: r, m: m});
      pend = pend & ~m;
    end
  endtask

  // One clock cycle: drive responses, compare every output with the model, then advance.
  task automatic cycle();
    bit held, subFire, last, inFire;
    int cur, g, idx;
    logic [NL-1:0] curM;
    logic [NR-1:0] expValid, expRspReady;
    if (!rspFreeze) begin
      for (int r = 0; r < NR; r++) begin
        out_rsp_valid[r] = (cnt[r] > 0) && ($urandom_range(0, 99) < rspPct);
        out_rsp_mask[r]  = NL'($urandom);
        out_rsp_tag[r]   = TW'($urandom);
        for (int l = 0; l < NL; l++) out_rsp_data[r][l] = $urandom;
      end
    end
    #2;
    held = subQ.size() > 0;
    expValid = '0; cur = 0; curM = '0;
    if (held) begin
      cur = subQ[0].r; curM = subQ[0].m;
      if (cnt[cur] < MAXP) expValid[cur] = 1'b1;
    end
    subFire = held && expValid[cur] && out_req_ready[cur];
    last    = subFire && subQ.size() == 1;
    checkOutput("out_req_valid", out_req_valid, expValid);
    checkOutput("in_req_ready", in_req_ready, !held || last);
    checkOutput("idle", idle, !held && cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0);
    if (expValid != '0) begin
      checkOutput("out_req_mask", out_req_mask[cur], curM);
      checkOutput("out_req_tag", out_req_tag[cur], hTag);
      checkOutput("out_req_rw", out_req_rw[cur], hRw);
      checkOutput("out_req_addr", out_req_addr[cur], hAddr);
      checkOutput("out_req_data", out_req_data[cur], hData);
      checkOutput("out_req_byteen", out_req_byteen[cur], hByteen);
      checkOutput("out_req_flags", out_req_flags[cur], hFlags);
    end
    g = -1;
    for (int i = 0; i < NR; i++) begin
      idx = (rrPtr + i) % NR;
      if (g < 0 && out_rsp_valid[idx]) g = idx;
    end
    expRspReady = '0;
    if (g >= 0) expRspReady[g] = in_rsp_ready;
    checkOutput("in_rsp_valid", in_rsp_valid, g >= 0);
    checkOutput("out_rsp_ready", out_rsp_ready, expRspReady);
    if (g >= 0) begin
      checkOutput("in_rsp_mask", in_rsp_mask, out_rsp_mask[g]);
      checkOutput("in_rsp_data", in_rsp_data, out_rsp_data[g]);
      checkOutput("in_rsp_tag", in_rsp_tag, out_rsp_tag[g]);
    end
    if (out_req_valid[1] && out_req_ready[1]) dutFires1++;
    inFire = in_req_valid && (!held || last);
    if (subFire) begin cnt[cur]++; void'(subQ.pop_front()); end
    if (g >= 0 && in_rsp_ready) begin cnt[g]--; rrPtr = (g + 1) % NR; end
    if (inFire && in_req_mask != '0) loadModel();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    in_req_valid = 1'b0; out_req_ready = '1; rspPct = 100; in_rsp_ready = 1'b1; rspFreeze = 1'b0;
    n = 0;
    while ((subQ.size() > 0 || cnt[0] + cnt[1] + cnt[2] > 0) && n < 60) begin cycle(); n++; end
    checkOutput("drain_done", n < 60, 1'b1);
  endtask

  initial begin
    clk = 0; errors = 0; checks = 0; rrPtr = 0; rspPct = 0; rspFreeze = 0; dutFires1 = 0;
    cnt = '{0, 0, 0};
    reset_n = 0;
    applyStimulus(0, '0, '0);
    out_req_ready = '0; in_rsp_ready = 1'b0;
    out_rsp_valid = '0; out_rsp_mask = '0; out_rsp_data = '0; out_rsp_tag = '0;
    #3;
    checkOutput("rst_in_req_ready", in_req_ready, 1'b1);
    checkOutput("rst_out_req_valid", out_req_valid, 3'b000);
    checkOutput("rst_in_rsp_valid", in_rsp_valid, 1'b0);
    checkOutput("rst_idle", idle, 1'b1);
    @(posedge clk); #1;
    reset_n = 1;

    $display("[TB] single-region request");
    out_req_ready = '1; in_rsp_ready = 1'b1; rspPct = 0;
    applyStimulus(1, 4'b1111, 8'b00_00_00_00);
    cycle();
    applyStimulus(0, '0, '0);
    checkOutput("t1_valid", out_req_valid, 3'b001);
    checkOutput("t1_mask", out_req_mask[0], 4'b1111);
    cycle();
    checkOutput("t1_idle", idle, 1'b0);
    drain();

    $display("[TB] split request across regions 0 and 2");
    rspPct = 0; out_req_ready = 3'b101;
    applyStimulus(1, 4'b1111, 8'b10_00_10_00);
    cycle();
    applyStimulus(0, '0, '0);
    checkOutput("split_first", out_req_mask[0], 4'b0101);
    cycle();
    checkOutput("split_second", out_req_mask[2], 4'b1010);
    cycle();
    drain();

    $display("[TB] outstanding limit stall");
    rspPct = 0; out_req_ready = '1;
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 4'b0011, 8'h00); cycle(); end
    applyStimulus(0, '0, '0);
    cycle();
    checkOutput("stall_valid", out_req_valid, 3'b000);
    cycle();
    rspPct = 100;
    cycle();
    rspPct = 0;
    checkOutput("stall_release", out_req_valid, 3'b001);
    cycle();
    drain();

    $display("[TB] response round-robin");
    rspPct = 0;
    for (int i = 0; i < 2; i++) begin applyStimulus(1, 4'b1111, 8'b00_10_01_00); cycle(); end
    applyStimulus(0, '0, '0);
    for (int i = 0; i < 8 && subQ.size() > 0; i++) cycle();
    rspPct = 100; in_rsp_ready = 1'b0;
    cycle();
    rspFreeze = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rspFreeze = 1'b0; in_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    drain();

    $display("[TB] back-to-back single-region requests");
    dutFires1 = 0; out_req_ready = '1; rspPct = 100; in_rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, NL'($urandom_range(1, 15)), 8'b01_01_01_01);
      cycle();
    end
    checkOutput("b2b_fires", dutFires1, 19);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), NL'($urandom), 8'($urandom));
      out_req_ready = NR'($urandom);
      rspPct = 60;
      in_rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("[TB] reset during split");
    rspPct = 0; out_req_ready = 3'b001;
    applyStimulus(1, 4'b1111, 8'b10_00_10_00);
    cycle();
    applyStimulus(0, '0, '0);
    cycle();
    #2;
    reset_n = 0;
    #1;
    checkOutput("mid_rst_valid", out_req_valid, 3'b000);
    checkOutput("mid_rst_idle", idle, 1'b1);
    checkOutput("mid_rst_ready", in_req_ready, 1'b1);
    subQ.delete(); cnt = '{0, 0, 0}; rrPtr = 0;
    @(posedge clk); #1;
    reset_n = 1;
    out_req_ready = '1;
    applyStimulus(1, 4'b0001, 8'h00);
    cycle();
    applyStimulus(0, '0, '0);
    cycle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
